// File: rtl/mat_pkg.sv
// ============================================================================
// Package : mat_pkg
// Shared types and constants for the 3x3 matrix-multiplication front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_pkg;

  // Load sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_PREP   = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } load_state_t;

  localparam int MAT_DWIDTH     = 16;
  localparam int MAT_AWIDTH     = 4;
  localparam int MAT_ELEMS      = 9;
  localparam int MAT_RUN_CYCLES = 20;

endpackage

`default_nettype wire

// File: rtl/mat_load_ctrl.sv
// ============================================================================
// Module  : mat_load_ctrl
// Streams 9 A words then 9 B words into the matrix engine RAM write port,
// parks the address at 0, holds start for RUN_CYCLES cycles and pulses done.
// Optional build macro: MAT_LOAD_STALL_CNT_EN adds the stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_load_ctrl
  import mat_pkg::*;
#(
  parameter int DWIDTH     = MAT_DWIDTH,
  parameter int AWIDTH     = MAT_AWIDTH,
  parameter int ELEMS      = MAT_ELEMS,
  parameter int RUN_CYCLES = MAT_RUN_CYCLES
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [DWIDTH-1:0] data_pi,
  output logic              we1,
  output logic              we2,
  output logic              start,
  output logic              busy,
`ifdef MAT_LOAD_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              done
);

  load_state_t       r_state;
  load_state_t       w_next;
  logic [AWIDTH-1:0] r_idx;
  logic [7:0]        r_run_cnt;
  logic              w_accept;
  logic              w_last;
  logic              w_loading;
  // First stage of the write-enable delay; second stage is the we outputs
  logic              r_acc_a;
  logic              r_acc_b;
  logic              r_we1;
  logic              r_we2;

  assign w_loading = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_accept  = in_valid && w_loading;
  assign w_last    = (r_idx == AWIDTH'(ELEMS - 1));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (go) w_next = ST_LOAD_A;
      ST_LOAD_A: if (w_accept && w_last) w_next = ST_LOAD_B;
      ST_LOAD_B: if (w_accept && w_last) w_next = ST_PREP;
      ST_PREP:   w_next = ST_RUN;
      ST_RUN:    if (r_run_cnt == 8'd0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so they drop with reset
  always_comb begin
    in_ready = w_loading;
    start    = (r_state == ST_RUN);
    done     = (r_state == ST_DONE);
    busy     = (r_state != ST_IDLE);
  end

  // Element index within the matrix currently being loaded
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        r_idx <= '0;
    else if (r_state == ST_IDLE && go)  r_idx <= '0;
    else if (w_accept)                  r_idx <= w_last ? '0 : r_idx + 1'b1;
  end

  // Address/data toward the engine; PREP parks the address at 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_pi <= '0;
      data_pi <= '0;
    end else if (w_accept) begin
      addr_pi <= r_idx;
      data_pi <= in_data;
    end else if (r_state == ST_PREP) begin
      addr_pi <= '0;
    end
  end

  // Two-stage delay of the accept strobe: the engine re-registers
  // addr/data, so its RAM write lands two cycles after the accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc_a <= 1'b0;
      r_acc_b <= 1'b0;
      r_we1   <= 1'b0;
      r_we2   <= 1'b0;
    end else begin
      r_acc_a <= w_accept && (r_state == ST_LOAD_A);
      r_acc_b <= w_accept && (r_state == ST_LOAD_B);
      r_we1   <= r_acc_a;
      r_we2   <= r_acc_b;
    end
  end

  assign we1 = r_we1;
  assign we2 = r_we2;

  // RUN window down-counter, loaded in PREP so RUN lasts RUN_CYCLES cycles
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                  r_run_cnt <= 8'd0;
    else if (r_state == ST_PREP)                  r_run_cnt <= 8'(RUN_CYCLES - 1);
    else if (r_state == ST_RUN && r_run_cnt != 0) r_run_cnt <= r_run_cnt - 8'd1;
  end

`ifdef MAT_LOAD_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count load cycles with no word offered; saturating
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        r_stall_cnt <= 16'd0;
    else if (r_state == ST_IDLE && go)  r_stall_cnt <= 16'd0;
    else if (w_loading && !in_valid && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mat_load_ctrl.sv
// ============================================================================
// Module  : tb_mat_load_ctrl
// Directed self-checking bench for mat_load_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_load_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  addr_pi;
  logic [15:0] data_pi;
  logic        we1, we2, start, busy, done;
`ifdef MAT_LOAD_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  mat_load_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .go       (go),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .addr_pi  (addr_pi),
    .data_pi  (data_pi),
    .we1      (we1),
    .we2      (we2),
    .start    (start),
    .busy     (busy),
`ifdef MAT_LOAD_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // Engine-side observer: the engine captures addr/data one cycle before
  // the write enable, so writes are recorded with the previous-cycle values
  logic [3:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;
  logic [19:0] wr_a[$];
  logic [19:0] wr_b[$];
  int start_cnt, done_cnt, done_cyc, first_start, both_we, start_addr_bad;

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (we1 === 1'b1) wr_a.push_back({prev_addr, prev_data});
      if (we2 === 1'b1) wr_b.push_back({prev_addr, prev_data});
      if (we1 === 1'b1 && we2 === 1'b1) both_we++;
      if (start === 1'b1) begin
        if (start_cnt == 0) first_start = cyc;
        start_cnt++;
        if (addr_pi !== 4'd0) start_addr_bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_addr = addr_pi;
    prev_data = data_pi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_a.delete();
    wr_b.delete();
    start_cnt = 0; done_cnt = 0; done_cyc = -1; first_start = -1;
    both_we = 0; start_addr_bad = 0;
  endtask

  task automatic pulse_go(output int g);
    go = 1'b1;
    g  = cyc;
    tick();
    go = 1'b0;
  endtask

  // Offer words first..first+n-1; optional idle cycle before each word
  task automatic stream_words(input int first, input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = 16'(first + k);
      check("in_ready_load", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy !== 1'b0 && n < lim) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    while (start !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    check("start_timeout", {31'd0, start}, 32'd1);
  endtask

  task automatic check_writes();
    check("wr_a_count", wr_a.size(), 32'd9);
    check("wr_b_count", wr_b.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check("wr_a_entry", {12'd0, wr_a[i]}, {12'd0, 4'(i), 16'(i + 1)});
      check("wr_b_entry", {12'd0, wr_b[i]}, {12'd0, 4'(i), 16'(i + 10)});
    end
    check("we_overlap", both_we, 32'd0);
  endtask

  int g;

  initial begin
    resetn   = 1'b0;
    go       = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'd0;
    clear_mon();

    // Reset state
    tick(); tick();
    check("rst_outputs", {23'd0, in_ready, we1, we2, start, busy, done, 3'd0},
          32'd0);
    check("rst_addr", {28'd0, addr_pi}, 32'd0);
    check("rst_data", {16'd0, data_pi}, 32'd0);
    resetn = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // Streaming load
    clear_mon();
    pulse_go(g);
    stream_words(1, 18, 1'b0);
    wait_idle(40);
    check_writes();
    check("stream_start_len", start_cnt, 32'd20);
    check("stream_start_first", first_start, g + 20);
    check("stream_start_addr", start_addr_bad, 32'd0);
    check("stream_done_cyc", done_cyc, g + 40);
    check("stream_done_cnt", done_cnt, 32'd1);

    // Stalled load: one idle cycle before every word
    clear_mon();
    pulse_go(g);
    stream_words(1, 18, 1'b1);
    wait_idle(40);
    check_writes();
    check("stall_start_len", start_cnt, 32'd20);
    check("stall_done_cyc", done_cyc, g + 58);
    check("stall_done_cnt", done_cnt, 32'd1);
`ifdef MAT_LOAD_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, 32'd18);
`endif

    // Reset at the 5th B accept
    clear_mon();
    pulse_go(g);
    stream_words(1, 9, 1'b0);
    stream_words(10, 4, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd14;
    check("mid_we2_before", {31'd0, we2}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_we2", {31'd0, we2}, 32'd0);
    check("mid_we1", {31'd0, we1}, 32'd0);
    check("mid_start", {31'd0, start}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ready", {31'd0, in_ready}, 32'd0);
    check("mid_addr", {28'd0, addr_pi}, 32'd0);
    in_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    clear_mon();
    pulse_go(g);
    stream_words(1, 18, 1'b0);
    wait_idle(40);
    check_writes();
    check("reload_done_cyc", done_cyc, g + 40);

    // go while busy is ignored
    clear_mon();
    pulse_go(g);
    stream_words(1, 18, 1'b0);
    wait_start(5);
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_idle(40);
    repeat (3) tick();
    check("gob_busy", {31'd0, busy}, 32'd0);
    check("gob_start_len", start_cnt, 32'd20);
    check("gob_done_cnt", done_cnt, 32'd1);
    check("gob_done_cyc", done_cyc, g + 40);

    // Reset during RUN drops start immediately
    clear_mon();
    pulse_go(g);
    stream_words(1, 18, 1'b0);
    wait_start(5);
    repeat (3) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("run_rst_start", {31'd0, start}, 32'd0);
    check("run_rst_busy", {31'd0, busy}, 32'd0);
    check("run_rst_done", {31'd0, done}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("run_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
